// File: rtl/flag_fifo_pkg.sv
// Shared UART package for the flag FIFO.
// Holds the default word width and FIFO depth used across the UART slice,
// and the encodings for the overflow policy selected by OVERWRITE.
package flag_fifo_pkg;

  // Defaults shared by the RX path and the bus-side register interface
  localparam int unsigned DEF_WORD_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 4;

  // Overflow policy encodings for the OVERWRITE parameter
  localparam int unsigned OVF_DROP      = 0;  // discard incoming word when full
  localparam int unsigned OVF_OVERWRITE = 1;  // replace oldest word when full

endpackage

// File: rtl/flag_fifo_mem.sv
// Register-array storage for flag_fifo.
// DEPTH x WORD_WIDTH array, synchronous write port, asynchronous read port.
// All entries clear on reset so the read port shows 0 straight after reset.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   we         : write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address
//   rdata      : read data, combinational from the array
module flag_fifo_mem
  import flag_fifo_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [WORD_WIDTH-1:0] rdata
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [WORD_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/flag_fifo.sv
// Multi-entry flag FIFO between the UART RX deserialiser and the bus-side
// register interface. First-word-fall-through: the head entry is always
// visible on dout. Provides occupancy, almost-full status, sticky
// overflow/underflow flags and a selectable overflow policy.
// Ports:
//   clk, rst_n    : clock (rising edge) and asynchronous active-low reset
//   wr_en, din    : push request and data
//   rd_en         : pop request for the head entry
//   dout          : head entry, combinational from storage
//   flag          : data available (count != 0)
//   full          : count == DEPTH
//   almost_full   : count >= AF_THRESH
//   count         : current occupancy
//   err_clear     : clears both sticky error flags
//   overflow_err  : sticky, push attempted while full (without a pop)
//   underflow_err : sticky, pop attempted while empty
module flag_fifo
  import flag_fifo_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AF_THRESH  = 3,
  parameter int unsigned OVERWRITE  = OVF_DROP,
  localparam int unsigned PW        = $clog2(DEPTH),
  localparam int unsigned CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [WORD_WIDTH-1:0] dout,
  output logic                  flag,
  output logic                  full,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  input  logic                  err_clear,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic is_empty;
  logic is_full;
  logic push_ok;
  logic pop_ok;
  logic ovf_evt;
  logic unf_evt;
  logic ovw_push;
  logic mem_we;

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));

    // A pop frees a slot in the same cycle, so a push alongside a pop is
    // always accepted, even when full. When empty, the pop is the underflow
    // and the push still lands (no bypass to dout).
    pop_ok   = rd_en & ~is_empty;
    push_ok  = wr_en & (~is_full | rd_en);
    ovf_evt  = wr_en & is_full & ~rd_en;
    unf_evt  = rd_en & is_empty;

    // Overwrite policy: store over the oldest entry and advance both
    // pointers, leaving count at DEPTH.
    ovw_push = ovf_evt & (OVERWRITE == OVF_OVERWRITE);
    mem_we   = push_ok | ovw_push;

    wr_ptr_d = wr_ptr_q + PW'(mem_we);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok | ovw_push);

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    // New error events win over a simultaneous clear
    ovf_d = ovf_evt | (ovf_q & ~err_clear);
    unf_d = unf_evt | (unf_q & ~err_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  flag_fifo_mem #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (din),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign count         = count_q;
  assign flag          = ~is_empty;
  assign full          = is_full;
  assign almost_full   = (count_q >= CW'(AF_THRESH));
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_flag_fifo.sv
// Self-checking bench for flag_fifo. Two instances share all inputs: index 0
// uses the drop policy, index 1 the overwrite policy. Each has its own
// queue-based reference model.
module tb_flag_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int CW = 3;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          rd_en;
  logic          err_clear;
  logic [W-1:0]  din;

  logic [W-1:0]  dout        [2];
  logic          flag        [2];
  logic          full        [2];
  logic          almost_full [2];
  logic [CW-1:0] count       [2];
  logic          ovf         [2];
  logic          unf         [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] mq [2][$];
  bit           ovf_m [2];
  bit           unf_m [2];

  flag_fifo #(
    .WORD_WIDTH (W),
    .DEPTH      (D),
    .AF_THRESH  (AF),
    .OVERWRITE  (0)
  ) dut_drop (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .din           (din),
    .rd_en         (rd_en),
    .dout          (dout[0]),
    .flag          (flag[0]),
    .full          (full[0]),
    .almost_full   (almost_full[0]),
    .count         (count[0]),
    .err_clear     (err_clear),
    .overflow_err  (ovf[0]),
    .underflow_err (unf[0])
  );

  flag_fifo #(
    .WORD_WIDTH (W),
    .DEPTH      (D),
    .AF_THRESH  (AF),
    .OVERWRITE  (1)
  ) dut_ovw (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .din           (din),
    .rd_en         (rd_en),
    .dout          (dout[1]),
    .flag          (flag[1]),
    .full          (full[1]),
    .almost_full   (almost_full[1]),
    .count         (count[1]),
    .err_clear     (err_clear),
    .overflow_err  (ovf[1]),
    .underflow_err (unf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue model: applies the current inputs for one clock edge
  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      int sz;
      bit ov;
      bit uf;
      sz = mq[m].size();
      ov = 0;
      uf = 0;
      if (wr_en && rd_en) begin
        if (sz == 0) begin
          mq[m].push_back(din);
          uf = 1;
        end else begin
          void'(mq[m].pop_front());
          mq[m].push_back(din);
        end
      end else if (wr_en) begin
        if (sz < D) begin
          mq[m].push_back(din);
        end else begin
          ov = 1;
          if (m == 1) begin
            void'(mq[m].pop_front());
            mq[m].push_back(din);
          end
        end
      end else if (rd_en) begin
        if (sz == 0) uf = 1;
        else void'(mq[m].pop_front());
      end
      ovf_m[m] = ov ? 1'b1 : (err_clear ? 1'b0 : ovf_m[m]);
      unf_m[m] = uf ? 1'b1 : (err_clear ? 1'b0 : unf_m[m]);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int sz;
      sz = mq[m].size();
      check($sformatf("count%0d", m), 32'(count[m]), 32'(sz));
      check($sformatf("flag%0d", m), 32'(flag[m]), 32'(sz != 0));
      check($sformatf("full%0d", m), 32'(full[m]), 32'(sz == D));
      check($sformatf("af%0d", m), 32'(almost_full[m]), 32'(sz >= AF));
      check($sformatf("ovf%0d", m), 32'(ovf[m]), 32'(ovf_m[m]));
      check($sformatf("unf%0d", m), 32'(unf[m]), 32'(unf_m[m]));
      if (sz != 0) check($sformatf("dout%0d", m), 32'(dout[m]), 32'(mq[m][0]));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("%s_dout%0d", tag, m), 32'(dout[m]), 32'h0);
      check($sformatf("%s_flag%0d", tag, m), 32'(flag[m]), 32'h0);
      check($sformatf("%s_full%0d", tag, m), 32'(full[m]), 32'h0);
      check($sformatf("%s_af%0d", tag, m), 32'(almost_full[m]), 32'h0);
      check($sformatf("%s_cnt%0d", tag, m), 32'(count[m]), 32'h0);
      check($sformatf("%s_ovf%0d", tag, m), 32'(ovf[m]), 32'h0);
      check($sformatf("%s_unf%0d", tag, m), 32'(unf[m]), 32'h0);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      ovf_m[m] = 0;
      unf_m[m] = 0;
    end
  endtask

  // Drive at the falling edge, advance one rising edge, then check at the
  // next falling edge.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d, input bit c);
    wr_en     = w;
    rd_en     = r;
    din       = d;
    err_clear = c;
    @(posedge clk);
    model_update();
    @(negedge clk);
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    err_clear = 1'b0;
    check_all();
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    err_clear = 1'b0;
    din       = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Fill / drain
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'(17 * (i + 1)), 0);
      check("fill_cnt", 32'(count[0]), 32'(i + 1));
      check("fill_af", 32'(almost_full[0]), 32'((i + 1) >= 3));
      check("fill_full", 32'(full[0]), 32'(i == 3));
    end
    for (int i = 0; i < 4; i++) begin
      check("drain_dout", 32'(dout[0]), 32'(17 * (i + 1)));
      step(0, 1, '0, 0);
    end
    check("drain_flag", 32'(flag[0]), 32'h0);
    check("drain_ovf", 32'(ovf[0]), 32'h0);
    check("drain_unf", 32'(unf[0]), 32'h0);

    // Overflow: drop vs overwrite
    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), 0);
    step(1, 0, 8'hAA, 0);
    check("ovf_drop_err", 32'(ovf[0]), 32'h1);
    check("ovf_ovw_err", 32'(ovf[1]), 32'h1);
    check("ovf_drop_cnt", 32'(count[0]), 32'd4);
    check("ovf_ovw_cnt", 32'(count[1]), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("ovf_drop_dout", 32'(dout[0]), 32'(i + 1));
      check("ovf_ovw_dout", 32'(dout[1]), (i < 3) ? 32'(i + 2) : 32'hAA);
      step(0, 1, '0, 0);
    end
    step(0, 0, '0, 1);

    // Underflow and clear, including error-beats-clear
    step(0, 1, '0, 0);
    check("unf_set", 32'(unf[0]), 32'h1);
    check("unf_cnt", 32'(count[0]), 32'h0);
    step(0, 0, '0, 1);
    check("unf_clr", 32'(unf[0]), 32'h0);
    step(0, 1, '0, 1);
    check("unf_prio", 32'(unf[0]), 32'h1);
    step(0, 0, '0, 1);

    // Simultaneous read/write while full
    for (int i = 1; i <= 4; i++) step(1, 0, 8'(i), 0);
    step(1, 1, 8'h55, 0);
    check("rw_full_cnt", 32'(count[1]), 32'd4);
    check("rw_full_ovf", 32'(ovf[1]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("rw_full_last", 32'(dout[0]), 32'h55);
      step(0, 1, '0, 0);
    end

    // Simultaneous read/write while empty
    step(1, 1, 8'h66, 0);
    check("rw_empty_cnt", 32'(count[0]), 32'd1);
    check("rw_empty_unf", 32'(unf[0]), 32'h1);
    check("rw_empty_dout", 32'(dout[0]), 32'h66);
    step(0, 1, '0, 1);

    // Pointer wrap: ten push/pop pairs
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'(8'h80 + i), 0);
      check("wrap_dout", 32'(dout[0]), 32'(8'h80 + i));
      step(0, 1, '0, 0);
    end

    // Asynchronous reset mid-stream with two entries buffered
    step(1, 0, 8'h21, 0);
    step(1, 0, 8'h22, 0);
    check("pre_rst_cnt", 32'(count[0]), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      bit w;
      bit r;
      bit c;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 15) == 0);
      step(w, r, 8'($urandom), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_fifo.md
Name: flag_fifo

Overview:
- Parametrised multi-entry successor to the UART single-word flag buffer.
- Sits between the UART RX deserialiser and the bus-side register interface.
- Buffers up to DEPTH words in first-word-fall-through order, with occupancy and almost-full status.
- Provides sticky overflow/underflow error flags and a selectable overflow policy: drop newest or overwrite oldest.

Parameters:
- WORD_WIDTH, 8, data word width in bits.
- DEPTH, 4, number of entries; power of two, minimum 2.
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- OVERWRITE, 0, 0 = drop incoming word when full; 1 = overwrite oldest word when full.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  push din this cycle.
- din  in  WORD_WIDTH  write data.
- rd_en  in  1  pop head entry this cycle.
- dout  out  WORD_WIDTH  head entry, combinational from storage.
- flag  out  1  data available (count != 0).
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy.
- err_clear  in  1  clear both sticky error flags.
- overflow_err  out  1  sticky; push attempted while full.
- underflow_err  out  1  sticky; pop attempted while empty.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
- Reset state:
  - Pointers, count, storage, overflow_err and underflow_err are 0.
  - dout = 0, flag = 0, full = 0, almost_full = 0.
- Registers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 by natural overflow. count is a separate register.
- flag, full and almost_full are decoded from count, with zero added latency relative to count.
- Write, not full: mem[wr_ptr] <= din, wr_ptr+1, count+1. The word appears on dout the next cycle if the FIFO was empty (FWFT latency 1).
- Read, not empty: rd_ptr+1, count-1. The next entry appears on dout in the same cycle the pointer updates.
- Read while empty:
  - No state change except underflow_err <= 1.
  - dout shows mem[rd_ptr] (stale data, not guaranteed meaningful).
- Write while full, no read:
  - OVERWRITE=0: din is discarded; pointers and count unchanged; overflow_err <= 1.
  - OVERWRITE=1: mem[wr_ptr] <= din, wr_ptr+1, rd_ptr+1, count stays DEPTH; overflow_err <= 1.
- Simultaneous wr_en & rd_en:
  - Not empty (including full): both pointers advance, count unchanged, no error. This holds in both OVERWRITE modes.
  - Empty: the write is accepted and the read is an underflow. Result: count = 1, underflow_err <= 1. There is no bypass, so din is not consumed.
- err_clear clears both error flags. A new error event in the same cycle takes priority (flag ends 1).
- Errors are status only; they never block further traffic.
- Reset asserted mid-operation: all state returns to reset values immediately; buffered contents are lost.
- No other states; control is pointer/count based, no FSM beyond this.

Decomposition:
- Shared uart package holds: default WORD_WIDTH, default FIFO depth, and the OVERWRITE mode encodings (OVF_DROP = 0, OVF_OVERWRITE = 1).
- One natural sub-module: flag_fifo_mem, a DEPTH x WORD_WIDTH register array with a synchronous write port and asynchronous read port.
- Pointer, count and error logic stay in flag_fifo.

Test Plan (DEPTH=4, WORD_WIDTH=8, AF_THRESH=3 unless stated):
- Fill/drain: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then pop 4 times.
  - count goes 1,2,3,4; almost_full rises at count=3; full at 4.
  - dout reads 0x11, 0x22, 0x33, 0x44 in order; flag drops after the 4th pop; no errors.
- Overflow drop (OVERWRITE=0): fill with 0x01..0x04, then push 0xAA.
  - overflow_err=1, count=4.
  - Draining yields 0x01..0x04; 0xAA is never seen.
- Overflow overwrite (OVERWRITE=1): fill with 0x01..0x04, then push 0xAA.
  - overflow_err=1, count=4.
  - Draining yields 0x02, 0x03, 0x04, 0xAA.
- Underflow and clear: pop while empty -> underflow_err=1, count=0. Then pulse err_clear -> underflow_err=0. Then pop-while-empty together with err_clear -> underflow_err=1.
- Simultaneous R/W:
  - Full FIFO + wr&rd with din=0x55: count stays 4, no overflow_err, 0x55 is last out.
  - Empty FIFO + wr&rd with din=0x66: count=1, underflow_err=1, dout=0x66 next cycle.
- Wrap and async reset: run 10 push/pop pairs so pointers wrap twice; data order is preserved. Assert rst_n low mid-stream with count=2: all outputs are 0 without waiting for a clock edge.
